// File: rtl/dff_sync_reset_pkg.sv
// ---------------------------------------------------------------------------
// dff_sync_reset_pkg
// Shared constants for the dff_sync_reset_pipe family:
//   - default WIDTH / DEPTH / RST_VAL of the pipeline
//   - fill_cnt_w(): width of the saturating fill counter for a given depth
// ---------------------------------------------------------------------------
package dff_sync_reset_pkg;

  localparam int         DFF_DEF_WIDTH   = 1;
  localparam int         DFF_DEF_DEPTH   = 1;
  localparam logic [0:0] DFF_DEF_RST_VAL = 1'b0;

  // The counter must hold the value DEPTH itself, hence DEPTH+1 states.
  function automatic int fill_cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_sync_reset_stage.sv
// ---------------------------------------------------------------------------
// dff_sync_reset_stage
// One WIDTH-bit register stage with asynchronous active-low reset, a
// synchronous clear and an advance enable. Both resets load RST_VAL.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   sync_reset synchronous clear, active-high (wins over en)
//   en         load d when high, hold when low
//   d          stage input
//   q          registered stage output
// ---------------------------------------------------------------------------
module dff_sync_reset_stage #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (sync_reset) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dff_sync_reset_pipe.sv
// ---------------------------------------------------------------------------
// dff_sync_reset_pipe
// DEPTH-stage registered delay line with asynchronous active-low reset and a
// synchronous clear. A saturating fill counter reports when DEPTH enabled
// advances have happened since the last reset/clear.
// Optional feature: define DFF_SYNC_RESET_PIPE_PARITY_EN to carry an even
// parity bit alongside every stage and report mismatches on q_par_err.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   sync_reset synchronous clear, active-high (wins over en)
//   en         stage advance enable
//   d          data in (WIDTH bits)
//   q          last stage output (WIDTH bits)
//   q_valid    high once DEPTH enabled advances have occurred
//   q_par_err  (parity build only) registered parity mismatch flag
// ---------------------------------------------------------------------------
module dff_sync_reset_pipe
  import dff_sync_reset_pkg::*;
#(
  parameter int               WIDTH   = DFF_DEF_WIDTH,
  parameter int               DEPTH   = DFF_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_DEF_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
  ,
  output logic             q_par_err
`endif
);

`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SW = WIDTH + PAR_W;

  // Parity bit (when present) sits in the MSB; it resets to 0 alongside data.
  localparam logic [SW-1:0] STAGE_RST = SW'(RST_VAL);

  localparam int            CW   = fill_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [SW-1:0] w_chain [0:DEPTH];
  logic [CW-1:0] r_fill;

`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
  assign w_chain[0] = {^d, d};
`else
  assign w_chain[0] = d;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dff_sync_reset_stage #(
      .WIDTH   (SW),
      .RST_VAL (STAGE_RST)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_reset (sync_reset),
      .en         (en),
      .d          (w_chain[k]),
      .q          (w_chain[k+1])
    );
  end

  // Fill counter: counts enabled advances, saturating at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (sync_reset) begin
      r_fill <= '0;
    end else if (en && (r_fill != FULL)) begin
      r_fill <= r_fill + CW'(1);
    end
  end

  assign q       = w_chain[DEPTH][WIDTH-1:0];
  assign q_valid = (r_fill == FULL);

`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
  logic r_par_err;

  // Only words that came from d are checked: reset values carry parity 0
  // regardless of RST_VAL, and they are flushed out exactly when q_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (sync_reset) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= q_valid && (^w_chain[DEPTH]);
    end
  end

  assign q_par_err = r_par_err;
`endif

endmodule

// File: tb/tb_dff_sync_reset_pipe.sv
// ---------------------------------------------------------------------------
// tb_dff_sync_reset_pipe
// Two instances: A = single-bit flop (defaults), B = 8-bit, 3-deep pipe with
// a non-zero RST_VAL. The reference keeps, per instance, a queue of the words
// accepted since the last reset/clear; q is the oldest of the last DEPTH
// accepted words, or RST_VAL until DEPTH words have been accepted.
// ---------------------------------------------------------------------------
module tb_dff_sync_reset_pipe;

  localparam int         B_W   = 8;
  localparam int         B_D   = 3;
  localparam logic [7:0] B_RST = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_sync, a_en, a_d;
  logic       b_sync, b_en;
  logic [7:0] b_d;
  logic       a_q, a_v, b_v;
  logic [7:0] b_q;
`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
  logic       a_pe, b_pe;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic       ha[$];
  logic [7:0] hb[$];

  always #10 clk = ~clk;

  dff_sync_reset_pipe u_a (
    .clk(clk), .rst_n(rst_n), .sync_reset(a_sync), .en(a_en),
    .d(a_d), .q(a_q), .q_valid(a_v)
`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
    , .q_par_err(a_pe)
`endif
  );

  dff_sync_reset_pipe #(.WIDTH(B_W), .DEPTH(B_D), .RST_VAL(B_RST)) u_b (
    .clk(clk), .rst_n(rst_n), .sync_reset(b_sync), .en(b_en),
    .d(b_d), .q(b_q), .q_valid(b_v)
`ifdef DFF_SYNC_RESET_PIPE_PARITY_EN
    , .q_par_err(b_pe)
`endif
  );

  function automatic logic exp_aq();
    return (ha.size() == 1) ? ha[0] : 1'b0;
  endfunction

  function automatic logic [7:0] exp_bq();
    return (hb.size() == B_D) ? hb[0] : B_RST;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one rising edge using the inputs seen there.
  task automatic model_edge();
    if (rst_n) begin
      if (a_sync) ha.delete();
      else if (a_en) begin
        ha.push_back(a_d);
        if (ha.size() > 1) void'(ha.pop_front());
      end
      if (b_sync) hb.delete();
      else if (b_en) begin
        hb.push_back(b_d);
        if (hb.size() > B_D) void'(hb.pop_front());
      end
    end
  endtask

  task automatic cmp_all();
    chk("a_q", 32'(a_q), 32'(exp_aq()));
    chk("a_valid", 32'(a_v), 32'(ha.size() == 1));
    chk("b_q", 32'(b_q), 32'(exp_bq()));
    chk("b_valid", 32'(b_v), 32'(hb.size() == B_D));
  endtask

  // One rising edge, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all();
  endtask

  // Random cycle with extra input changes between edges; those must not
  // reach q before the next rising edge.
  task automatic rand_step();
    @(posedge clk);
    model_edge();
    #3 a_d = 1'($urandom); b_d = 8'($urandom);
    #3 a_en = ($urandom_range(0, 3) != 0); b_en = ($urandom_range(0, 3) != 0);
    a_sync = ($urandom_range(0, 7) == 0); b_sync = ($urandom_range(0, 7) == 0);
    @(negedge clk);
    cmp_all();
    #2 a_d = 1'($urandom); b_d = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    a_sync = 1'b0; a_en = 1'b1; a_d = 1'b0;
    b_sync = 1'b0; b_en = 1'b1; b_d = 8'h00;

    // Power-on: clock running, d toggling, reset held.
    for (int i = 0; i < 4; i++) begin
      a_d = ~a_d; b_d = 8'($urandom);
      step();
      chk("por_a_q", 32'(a_q), 32'h0);
      chk("por_b_q", 32'(b_q), 32'h5A);
      chk("por_valid", 32'({a_v, b_v}), 32'h0);
    end
    rst_n = 1'b1;

    // Directed sequence with literal expectations.
    a_en = 1'b1; a_d = 1'b1; b_en = 1'b1; b_d = 8'hA5;
    step();
    chk("lit_a_first", 32'(a_q), 32'h1);
    chk("lit_b_e1_q", 32'(b_q), 32'h5A);
    chk("lit_b_e1_v", 32'(b_v), 32'h0);
    a_en = 1'b0; a_d = 1'b0; b_d = 8'h3C;
    step();
    chk("lit_a_hold1", 32'(a_q), 32'h1);
    b_d = 8'hFF;
    step();
    chk("lit_a_hold2", 32'(a_q), 32'h1);
    chk("lit_b_e3_q", 32'(b_q), 32'hA5);
    chk("lit_b_e3_v", 32'(b_v), 32'h1);
    b_d = 8'h11; b_sync = 1'b1;
    step();
    chk("lit_a_hold3", 32'(a_q), 32'h1);
    chk("lit_b_clr_q", 32'(b_q), 32'h5A);
    chk("lit_b_clr_v", 32'(b_v), 32'h0);
    a_sync = 1'b1; a_en = 1'b0; a_d = 1'b1; b_sync = 1'b0; b_d = 8'h22;
    step();
    chk("lit_a_clr_q", 32'(a_q), 32'h0);
    chk("lit_a_clr_v", 32'(a_v), 32'h0);
    chk("lit_b_after_clr", 32'(b_q), 32'h5A);
    a_sync = 1'b0; a_en = 1'b1; a_d = 1'b1;
    step();
    chk("lit_a_resume", 32'(a_q), 32'h1);
    chk("lit_a_resume_v", 32'(a_v), 32'h1);

    // Sync + en together: clear wins, d discarded.
    a_sync = 1'b1; a_en = 1'b1; a_d = 1'b1; b_sync = 1'b1; b_en = 1'b1; b_d = 8'hC3;
    step();
    chk("lit_both_a", 32'(a_q), 32'h0);
    chk("lit_both_b", 32'(b_q), 32'h5A);
    a_sync = 1'b0; b_sync = 1'b0;

    // Randomized run.
    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset mid-cycle, no edge required.
    @(posedge clk);
    model_edge();
    #4 rst_n = 1'b0;
    ha.delete(); hb.delete();
    #1;
    chk("async_a_q", 32'(a_q), 32'h0);
    chk("async_b_q", 32'(b_q), 32'h5A);
    chk("async_valid", 32'({a_v, b_v}), 32'h0);
    @(negedge clk);
    cmp_all();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) rand_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
